vga_timings_gen: RTL and testbench



---
 rtl/vga_timings_gen.sv | 79 +++++++
 tb/tb_vga_timings_gen.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/vga_timings_gen.sv
// Free-running VGA raster timing generator with signed coordinates; blanking maps to negative sx/sy.
// Define VGA_TIMINGS_POS_SYNC_EN for active-high hsync/vsync (default active-low).
module vga_timings_gen #(
  parameter int CORDW  = 16,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                    clk_pix,
  input  logic                    rst,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame,
  output logic                    line
);

  localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [CORDW-1:0] HS_STA = CORDW'(-(H_SYNC + H_BP));
  localparam logic signed [CORDW-1:0] HS_END = CORDW'(-H_BP);
  localparam logic signed [CORDW-1:0] HA_END = CORDW'(H_RES - 1);
  localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [CORDW-1:0] VS_STA = CORDW'(-(V_SYNC + V_BP));
  localparam logic signed [CORDW-1:0] VS_END = CORDW'(-V_BP);
  localparam logic signed [CORDW-1:0] VA_END = CORDW'(V_RES - 1);

`ifdef VGA_TIMINGS_POS_SYNC_EN
  localparam logic SYNC_ACT = 1'b1;
`else
  localparam logic SYNC_ACT = 1'b0;
`endif

  logic signed [CORDW-1:0] x, y;
  logic                    hs_win, vs_win;

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      x <= H_STA;
      y <= V_STA;
    end else if (x == HA_END) begin
      x <= H_STA;
      y <= (y == VA_END) ? V_STA : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  assign hs_win = (x > HS_STA) && (x <= HS_END);
  assign vs_win = (y > VS_STA) && (y <= VS_END);

  // Every output is registered from x/y so all share the same one-cycle latency.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      sx    <= H_STA;
      sy    <= V_STA;
      hsync <= ~SYNC_ACT;
      vsync <= ~SYNC_ACT;
      de    <= 1'b0;
      frame <= 1'b0;
      line  <= 1'b0;
    end else begin
      sx    <= x;
      sy    <= y;
      hsync <= hs_win ? SYNC_ACT : ~SYNC_ACT;
      vsync <= vs_win ? SYNC_ACT : ~SYNC_ACT;
      de    <= ~x[CORDW-1] && ~y[CORDW-1];
      frame <= (x == H_STA) && (y == V_STA);
      line  <= (x == H_STA);
    end
  end

endmodule

// File: tb/tb_vga_timings_gen.sv
// Bench for vga_timings_gen: default 640x480 instance plus a tiny-mode instance, checked against a raster-position model.
module tb_vga_timings_gen;

`ifdef VGA_TIMINGS_POS_SYNC_EN
  localparam bit POS = 1'b1;
`else
  localparam bit POS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [15:0] sx0, sy0, sx1, sy1;
  logic hs0, vs0, de0, fr0, ln0, hs1, vs1, de1, fr1, ln1;
  int passes = 0, total = 0, n = 0;

  always #5 clk = ~clk;

  vga_timings_gen u_dut (
    .clk_pix(clk), .rst(rst), .sx(sx0), .sy(sy0), .hsync(hs0), .vsync(vs0),
    .de(de0), .frame(fr0), .line(ln0)
  );

  vga_timings_gen #(
    .CORDW(16), .H_RES(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .clk_pix(clk), .rst(rst), .sx(sx1), .sy(sy1), .hsync(hs1), .vsync(vs1),
    .de(de1), .frame(fr1), .line(ln1)
  );

  // Expected outputs after n clock edges since reset release (n=0 means held in reset).
  function automatic logic [36:0] ref_out(input int n, input int hres, hfp, hsw, hbp,
                                          input int vres, vfp, vsw, vbp);
    int ht, vt, p, col, row, x, y;
    logic hact, vact, hs, vs, de, fr, ln;
    ht = hres + hfp + hsw + hbp;
    vt = vres + vfp + vsw + vbp;
    if (n == 0)
      return {16'(-(hfp + hsw + hbp)), 16'(-(vfp + vsw + vbp)), ~POS, ~POS, 3'b000};
    p   = (n - 1) % (ht * vt);
    col = p % ht;
    row = p / ht;
    x   = col - (hfp + hsw + hbp);
    y   = row - (vfp + vsw + vbp);
    hact = (x > -(hsw + hbp)) && (x <= -hbp);
    vact = (y > -(vsw + vbp)) && (y <= -vbp);
    hs = POS ? hact : ~hact;
    vs = POS ? vact : ~vact;
    de = (x >= 0) && (y >= 0);
    fr = (p == 0);
    ln = (col == 0);
    return {16'(x), 16'(y), hs, vs, de, fr, ln};
  endfunction

  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_both(input string tag);
    chk({tag, "_def"}, {sx0, sy0, hs0, vs0, de0, fr0, ln0}, ref_out(n, 640, 16, 96, 48, 480, 10, 2, 33));
    chk({tag, "_small"}, {sx1, sy1, hs1, vs1, de1, fr1, ln1}, ref_out(n, 8, 1, 2, 1, 4, 1, 1, 1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    check_both("run");
  endtask

  // Assert reset between edges, check immediately, release away from the active edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 n = 0;
    check_both("rst_async");
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  int ln_first, ln_second, hs_cnt, hs_min, hs_max;
  int fr_first, fr_second, de_cnt, wraps, wrap_bad;
  logic signed [15:0] psx, psy;

  initial begin
    #1 rst = 1'b1;
    #2 check_both("rst_init");
    @(negedge clk);
    #1 rst = 1'b0;
    n = 0;

    // Randomly long runs, each ended by a mid-cycle reset.
    for (int t = 0; t < 5; t++) begin
      int len;
      len = $urandom_range(1, 3000);
      for (int i = 0; i < len; i++) step();
      do_reset();
    end

    // Directed measurements from a fresh reset.
    ln_first = -1; ln_second = -1; hs_cnt = 0; hs_min = 100000; hs_max = -100000;
    fr_first = -1; fr_second = -1; de_cnt = 0; wraps = 0; wrap_bad = 0;
    psx = sx1; psy = sy1;
    for (int i = 1; i <= 1700; i++) begin
      step();
      if (ln0) begin
        if (ln_first < 0) ln_first = i;
        else if (ln_second < 0) ln_second = i;
      end
      if (i <= 800 && hs0 == POS) begin
        hs_cnt++;
        if (sx0 < hs_min) hs_min = sx0;
        if (sx0 > hs_max) hs_max = sx0;
      end
      if (fr1) begin
        if (fr_first < 0) fr_first = i;
        else if (fr_second < 0) fr_second = i;
      end
      if (i <= 84 && de1) de_cnt++;
      if (psy == 16'sd3 && sy1 == -16'sd3) begin
        wraps++;
        if (!(psx == 16'sd7 && sx1 == -16'sd4)) wrap_bad++;
      end
      psx = sx1; psy = sy1;
    end
    chk_int("line_first", ln_first, 1);
    chk_int("line_period", ln_second - ln_first, 800);
    chk_int("hsync_width", hs_cnt, 96);
    chk_int("hsync_sx_min", hs_min, -143);
    chk_int("hsync_sx_max", hs_max, -48);
    chk_int("small_frame_first", fr_first, 1);
    chk_int("small_frame_period", fr_second - fr_first, 84);
    chk_int("small_de_count", de_cnt, 32);
    chk_int("small_wraps_seen", wraps, 20);
    chk_int("small_wrap_align", wrap_bad, 0);

    do_reset();
    step();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
